framebuffer_arbiter: RTL and testbench
======================================

Name: framebuffer_arbiter

Overview:
- Shares one single-port synchronous frame-buffer SRAM between the VGA display fetch path and a host write requester.
- Consumes the pixel strobe and the column/row/address counts from the VGA timing block.
- Display fetch always has priority. Host writes fill the non-strobe cycles and the blanking intervals.
- Drives the registered pixel value toward the DAC/colour stage.

Parameters:
- DATA_W, 8, pixel/SRAM word width
- ADDR_W, 20, SRAM address width; matches the timing block address count
- H_ACTIVE, 640, visible columns (col 0..H_ACTIVE-1)
- V_ACTIVE, 480, visible rows (row 0..V_ACTIVE-1)

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- enable  in  1  display fetch enable (level)
- pixel_clk  in  1  one-clk pulse per pixel, from timing block
- col_cnt  in  10  current column 0..799
- row_cnt  in  10  current row 0..524
- pix_addr  in  ADDR_W  SRAM address of current pixel
- wr_req  in  1  host write request (level, held until ack)
- wr_addr  in  ADDR_W  host write address
- wr_data  in  DATA_W  host write data
- wr_ack  out  1  one-clk pulse: write issued
- mem_addr  out  ADDR_W  SRAM address (registered)
- mem_wdata  out  DATA_W  SRAM write data (registered)
- mem_we  out  1  SRAM write strobe (registered)
- mem_re  out  1  SRAM read strobe (registered)
- mem_rdata  in  DATA_W  SRAM read data, valid one clk after mem_re
- pixel_data  out  DATA_W  displayed pixel, 0 when blanked
- pixel_valid  out  1  one-clk pulse: pixel_data updated from SRAM

Behaviour:
- Clock and reset:
  - One clock, clk. Reset n_rst is asynchronous, active-low.
  - On reset, every output is 0 and the FSM goes to OFF.
  - Reset mid-operation drops any in-flight read capture and any pending ack; the host re-requests.
- Active region: active = (col_cnt < H_ACTIVE) && (row_cnt < V_ACTIVE), decoded combinationally from inputs at the sampling edge.
- Frame FSM states: OFF, SYNC, RUN.
  - OFF -> SYNC when enable=1.
  - SYNC -> RUN at the edge where pixel_clk=1, col_cnt=0 and row_cnt=0. That first pixel is fetched on the same edge.
  - Any state -> OFF when enable=0, at the next edge. A read already issued still completes its capture.
- Fetch request: fetch = (state==RUN or the SYNC->RUN edge) && pixel_clk && active.
- Grant, evaluated at each edge, priority order:
  - fetch: mem_re<=1, mem_we<=0, mem_addr<=pix_addr.
  - else wr_req && !wr_ack: mem_we<=1, mem_re<=0, mem_addr<=wr_addr, mem_wdata<=wr_data, wr_ack<=1.
  - else mem_re<=0, mem_we<=0. mem_addr and mem_wdata hold their values.
- mem_re and mem_we are never both 1.
- Handshake:
  - The host holds wr_req, wr_addr and wr_data stable until it sees wr_ack=1.
  - The host may present a new request in the cycle after the ack.
  - The !wr_ack term makes back-to-back grants of the same request impossible. Peak write rate is one per 2 clks.
- Read pipeline latency:
  - Edge E: fetch sampled.
  - E+1: mem_re high.
  - E+2: pixel_data<=mem_rdata and pixel_valid<=1 for one clk.
  - Total: 2 clks from the strobe edge to pixel_valid.
- Blanking:
  - If a pixel_clk edge has !active, or the state is not RUN, pixel_data<=0 two clks later with pixel_valid=0. This keeps the pipeline alignment.
  - Otherwise pixel_data holds.
- Write conflict bound:
  - pixel_clk pulses on alternate clks, so a write waits at most 1 clk in the active region and 0 clks in blanking or OFF.
  - Writes are allowed in every FSM state.
- Wrap-around: at end of frame (col 799, row 524 -> 0,0) nothing special occurs in RUN; fetches resume when active.

Optional Feature:
- FBARB_BLANK_WR_ONLY_EN:
  - When defined, write grants additionally require !active or state!=RUN. In RUN, writes occur only during horizontal or vertical blanking (tear-free updates).
  - When not defined, writes interleave with fetches as described above.
  - Fetch behaviour is identical in both builds.

Decomposition:
- Package fbarb_pkg:
  - enum fbarb_state_t {OFF, SYNC, RUN}
  - localparams H_TOTAL=800, V_TOTAL=525, default H_ACTIVE/V_ACTIVE
- Single module; no sub-module. The grant logic and the 2-stage read pipeline stay local.

Test Plan:
- Reset asserted mid-RUN with mem_re=1 -> all outputs 0 immediately. No pixel_valid after reset release; FSM=OFF.
- enable=1 at col=100,row=3 -> no mem_re until col=0,row=0 strobe. mem_re with mem_addr=0 one clk later; pixel_valid with pixel_data=mem_rdata (0xA5) at +2 clks.
- wr_req with addr=0x00123, data=0x3C, asserted on a pixel_clk edge in the active region:
  - fetch wins that edge.
  - mem_we=1, addr=0x00123, wdata=0x3C one clk later; wr_ack a single pulse.
- wr_req held continuously in OFF -> one write per 2 clks, every grant paired with a single wr_ack, never mem_re.
- Strobe at col=640,row=10 -> no mem_re; pixel_data=0 and pixel_valid=0 two clks later.
- With FBARB_BLANK_WR_ONLY_EN, wr_req at col=200,row=50 in RUN -> no mem_we until col=640. Then mem_we=1, wr_ack=1.

Source files
------------

// File: rtl/fbarb_pkg.sv
// ============================================================================
// Module   : fbarb_pkg
// Purpose  : Shared state encoding and VGA frame constants for the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fbarb_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } fbarb_state_t;

    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 525;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

endpackage

`default_nettype wire

// File: rtl/framebuffer_arbiter.sv
// ============================================================================
// Module   : framebuffer_arbiter
// Purpose  : Shares one SRAM port between display fetch (priority) and host
//            writes; FBARB_BLANK_WR_ONLY_EN confines RUN-state writes to blanking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module framebuffer_arbiter
    import fbarb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 20,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              enable,
    input  logic              pixel_clk,
    input  logic [9:0]        col_cnt,
    input  logic [9:0]        row_cnt,
    input  logic [ADDR_W-1:0] pix_addr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pixel_data,
    output logic              pixel_valid
);

    localparam logic [9:0] C_H_ACT = 10'(H_ACTIVE);
    localparam logic [9:0] C_V_ACT = 10'(V_ACTIVE);

    fbarb_state_t      state_q, state_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              wr_ack_q, wr_ack_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cap_q, cap_d;
    logic              blank1_q, blank1_d;
    logic              blank2_q, blank2_d;
    logic [DATA_W-1:0] pixel_data_q, pixel_data_d;
    logic              pixel_valid_q, pixel_valid_d;

    logic w_active;
    logic w_sync_edge;
    logic w_fetch;
    logic w_blank;
    logic w_wr_ok;

    always_comb begin
        w_active    = (col_cnt < C_H_ACT) && (row_cnt < C_V_ACT);
        w_sync_edge = (state_q == SYNC) && enable && pixel_clk &&
                      (col_cnt == 10'd0) && (row_cnt == 10'd0);
        w_fetch     = ((state_q == RUN) || w_sync_edge) && pixel_clk && w_active;
        // A strobe that does not fetch still marches a blank through the pipe
        w_blank     = pixel_clk && !w_fetch;
`ifdef FBARB_BLANK_WR_ONLY_EN
        w_wr_ok     = wr_req && !wr_ack_q && (!w_active || (state_q != RUN));
`else
        w_wr_ok     = wr_req && !wr_ack_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF:     if (enable) state_d = SYNC;
            SYNC:    if (w_sync_edge) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = OFF;
        endcase
        if (!enable) state_d = OFF;
    end

    always_comb begin
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        wr_ack_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (w_fetch) begin
            mem_re_d   = 1'b1;
            mem_addr_d = pix_addr;
        end else if (w_wr_ok) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
            wr_ack_d    = 1'b1;
        end
    end

    always_comb begin
        cap_d         = mem_re_q;
        blank1_d      = w_blank;
        blank2_d      = blank1_q;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = 1'b0;
        if (cap_q) begin
            pixel_data_d  = mem_rdata;
            pixel_valid_d = 1'b1;
        end else if (blank2_q) begin
            pixel_data_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= OFF;
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            wr_ack_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cap_q         <= 1'b0;
            blank1_q      <= 1'b0;
            blank2_q      <= 1'b0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_re_q      <= mem_re_d;
            mem_we_q      <= mem_we_d;
            wr_ack_q      <= wr_ack_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            cap_q         <= cap_d;
            blank1_q      <= blank1_d;
            blank2_q      <= blank2_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

    assign wr_ack      = wr_ack_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;
    assign pixel_data  = pixel_data_q;
    assign pixel_valid = pixel_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_framebuffer_arbiter.sv
// ============================================================================
// Module   : tb_framebuffer_arbiter
// Purpose  : Directed self-checking bench for framebuffer_arbiter
//            (define FBARB_BLANK_WR_ONLY_EN for the blanking-only write build).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_framebuffer_arbiter;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              enable;
    logic              pixel_clk;
    logic [9:0]        col_cnt;
    logic [9:0]        row_cnt;
    logic [ADDR_W-1:0] pix_addr;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] pixel_data;
    logic              pixel_valid;

    int n_tests = 0;
    int n_fail  = 0;

    framebuffer_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .enable      (enable),
        .pixel_clk   (pixel_clk),
        .col_cnt     (col_cnt),
        .row_cnt     (row_cnt),
        .pix_addr    (pix_addr),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid)
    );

    always #5 clk = ~clk;

    // SRAM stand-in: address 0 holds 0xA5, elsewhere low address byte ^ 0x5A
    always @(posedge clk) begin
        if (mem_re)
            mem_rdata <= (mem_addr == '0) ? 8'hA5 : (mem_addr[7:0] ^ 8'h5A);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [9:0] c, input logic [9:0] r);
        col_cnt   = c;
        row_cnt   = r;
        pix_addr  = ADDR_W'(r) * 20'd640 + ADDR_W'(c);
        pixel_clk = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; enable = 1'b0; pixel_clk = 1'b0; col_cnt = '0; row_cnt = '0;
        pix_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; mem_rdata = '0;
        step(); step();
        n_tests++;
        if ({wr_ack, mem_we, mem_re, pixel_valid} !== 4'b0000 || mem_addr !== '0 ||
            mem_wdata !== '0 || pixel_data !== '0) begin
            $display("FAIL reset_outputs: ack=%b we=%b re=%b pv=%b addr=%h wd=%h pd=%h, required all 0",
                     wr_ack, mem_we, mem_re, pixel_valid, mem_addr, mem_wdata, pixel_data);
            n_fail++;
        end
        n_rst = 1'b1;
        step();
    endtask

    task automatic test_sync_fetch();
        enable = 1'b1;
        strobe(10'd100, 10'd3);
        step();
        n_tests++;
        if (mem_re !== 1'b0) begin
            $display("FAIL sync_no_read_mid_frame: mem_re=%b required 0", mem_re); n_fail++;
        end
        pixel_clk = 1'b0; step();
        strobe(10'd101, 10'd3);
        step();
        n_tests++;
        if (mem_re !== 1'b0) begin
            $display("FAIL sync_wait_origin: mem_re=%b required 0", mem_re); n_fail++;
        end
        pixel_clk = 1'b0; step();
        strobe(10'd0, 10'd0);
        step();
        n_tests++;
        if (mem_re !== 1'b1 || mem_addr !== 20'h0 || mem_we !== 1'b0) begin
            $display("FAIL first_fetch: re=%b addr=%h we=%b required re=1 addr=0 we=0",
                     mem_re, mem_addr, mem_we); n_fail++;
        end
        pixel_clk = 1'b0;
        step();
        n_tests++;
        if (pixel_valid !== 1'b0 || mem_re !== 1'b0) begin
            $display("FAIL first_fetch_latency: pv=%b re=%b required 0 0", pixel_valid, mem_re); n_fail++;
        end
        step();
        n_tests++;
        if (pixel_valid !== 1'b1 || pixel_data !== 8'hA5) begin
            $display("FAIL first_pixel: pv=%b pd=%h required 1 a5", pixel_valid, pixel_data); n_fail++;
        end
        step();
        n_tests++;
        if (pixel_valid !== 1'b0 || pixel_data !== 8'hA5) begin
            $display("FAIL pixel_hold: pv=%b pd=%h required 0 a5", pixel_valid, pixel_data); n_fail++;
        end
    endtask

    task automatic test_write_conflict();
        strobe(10'd1, 10'd0);
        wr_req = 1'b1; wr_addr = 20'h00123; wr_data = 8'h3C;
        step();
        n_tests++;
        if (mem_re !== 1'b1 || mem_we !== 1'b0 || wr_ack !== 1'b0 || mem_addr !== 20'h00001) begin
            $display("FAIL conflict_fetch_wins: re=%b we=%b ack=%b addr=%h required 1 0 0 00001",
                     mem_re, mem_we, wr_ack, mem_addr); n_fail++;
        end
        pixel_clk = 1'b0;
        step();
        n_tests++;
        if (mem_we !== 1'b1 || mem_re !== 1'b0 || wr_ack !== 1'b1 ||
            mem_addr !== 20'h00123 || mem_wdata !== 8'h3C) begin
            $display("FAIL conflict_write: we=%b re=%b ack=%b addr=%h wd=%h required 1 0 1 00123 3c",
                     mem_we, mem_re, wr_ack, mem_addr, mem_wdata); n_fail++;
        end
        wr_req = 1'b0;
        step();
        n_tests++;
        if (wr_ack !== 1'b0 || mem_we !== 1'b0 || pixel_valid !== 1'b1 || pixel_data !== 8'h5B) begin
            $display("FAIL conflict_after: ack=%b we=%b pv=%b pd=%h required 0 0 1 5b",
                     wr_ack, mem_we, pixel_valid, pixel_data); n_fail++;
        end
    endtask

    task automatic test_blank_strobe();
        strobe(10'd640, 10'd10);
        step();
        n_tests++;
        if (mem_re !== 1'b0) begin
            $display("FAIL blank_no_read: mem_re=%b required 0", mem_re); n_fail++;
        end
        pixel_clk = 1'b0;
        step();
        n_tests++;
        if (pixel_data !== 8'h5B || pixel_valid !== 1'b0) begin
            $display("FAIL blank_alignment: pd=%h pv=%b required 5b 0", pixel_data, pixel_valid); n_fail++;
        end
        step();
        n_tests++;
        if (pixel_data !== 8'h00 || pixel_valid !== 1'b0) begin
            $display("FAIL blank_zero: pd=%h pv=%b required 00 0", pixel_data, pixel_valid); n_fail++;
        end
    endtask

    task automatic test_blank_write();
`ifdef FBARB_BLANK_WR_ONLY_EN
        strobe(10'd200, 10'd50);
        wr_req = 1'b1; wr_addr = 20'h00200; wr_data = 8'h11;
        for (int i = 0; i < 3; i++) begin
            step();
            pixel_clk = 1'b0;
            n_tests++;
            if (mem_we !== 1'b0 || wr_ack !== 1'b0) begin
                $display("FAIL blank_only_hold: cycle=%0d we=%b ack=%b required 0 0", i, mem_we, wr_ack);
                n_fail++;
            end
        end
        strobe(10'd640, 10'd50);
        step();
        n_tests++;
        if (mem_we !== 1'b1 || wr_ack !== 1'b1 || mem_addr !== 20'h00200 || mem_wdata !== 8'h11) begin
            $display("FAIL blank_only_grant: we=%b ack=%b addr=%h wd=%h required 1 1 00200 11",
                     mem_we, wr_ack, mem_addr, mem_wdata); n_fail++;
        end
`else
        strobe(10'd700, 10'd10);
        wr_req = 1'b1; wr_addr = 20'h00456; wr_data = 8'h77;
        step();
        n_tests++;
        if (mem_we !== 1'b1 || wr_ack !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 20'h00456) begin
            $display("FAIL blank_write_same_edge: we=%b ack=%b re=%b addr=%h required 1 1 0 00456",
                     mem_we, wr_ack, mem_re, mem_addr); n_fail++;
        end
`endif
        wr_req = 1'b0; pixel_clk = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_write_burst_off();
        int grants = 0;
        int acks   = 0;
        enable = 1'b0; wr_req = 1'b0; pixel_clk = 1'b0;
        step();
        wr_req = 1'b1; wr_addr = 20'h00010; wr_data = 8'h20;
        for (int i = 0; i < 8; i++) begin
            step();
            n_tests++;
            if (mem_re !== 1'b0 || mem_we !== wr_ack) begin
                $display("FAIL burst_cycle: cycle=%0d re=%b we=%b ack=%b required re=0 we==ack",
                         i, mem_re, mem_we, wr_ack); n_fail++;
            end
            if (mem_we === 1'b1) begin
                grants++;
                n_tests++;
                if (mem_addr !== wr_addr || mem_wdata !== wr_data) begin
                    $display("FAIL burst_payload: cycle=%0d addr=%h wd=%h required %h %h",
                             i, mem_addr, mem_wdata, wr_addr, wr_data); n_fail++;
                end
            end
            if (wr_ack === 1'b1) begin
                acks++;
                wr_addr = wr_addr + 20'd1;
                wr_data = wr_data + 8'd1;
            end
        end
        n_tests++;
        if (grants != 4 || acks != 4) begin
            $display("FAIL burst_rate: grants=%0d acks=%0d required 4 4", grants, acks); n_fail++;
        end
        wr_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_run();
        enable = 1'b1;
        step();
        strobe(10'd0, 10'd0);
        step();
        pixel_clk = 1'b0;
        step();
        strobe(10'd2, 10'd0);
        step();
        pixel_clk = 1'b0;
        n_tests++;
        if (mem_re !== 1'b1 || mem_addr !== 20'h00002 || pixel_valid !== 1'b1) begin
            $display("FAIL rerun_fetch: re=%b addr=%h pv=%b required 1 00002 1",
                     mem_re, mem_addr, pixel_valid); n_fail++;
        end
        n_rst = 1'b0;
        #1;
        n_tests++;
        if ({wr_ack, mem_we, mem_re, pixel_valid} !== 4'b0000 || mem_addr !== '0 ||
            mem_wdata !== '0 || pixel_data !== '0) begin
            $display("FAIL async_reset: ack=%b we=%b re=%b pv=%b addr=%h wd=%h pd=%h, required all 0",
                     wr_ack, mem_we, mem_re, pixel_valid, mem_addr, mem_wdata, pixel_data);
            n_fail++;
        end
        step(); step();
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (pixel_valid !== 1'b0) begin
                $display("FAIL reset_drops_capture: cycle=%0d pv=%b required 0", i, pixel_valid);
                n_fail++;
            end
        end
        strobe(10'd4, 10'd0);
        step();
        n_tests++;
        if (mem_re !== 1'b0) begin
            $display("FAIL reset_state_off: mem_re=%b required 0", mem_re); n_fail++;
        end
        pixel_clk = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_sync_fetch();
`ifndef FBARB_BLANK_WR_ONLY_EN
        test_write_conflict();
`else
        strobe(10'd1, 10'd0);
        step();
        pixel_clk = 1'b0;
        step(); step();
        n_tests++;
        if (pixel_valid !== 1'b1 || pixel_data !== 8'h5B) begin
            $display("FAIL run_fetch: pv=%b pd=%h required 1 5b", pixel_valid, pixel_data); n_fail++;
        end
`endif
        test_blank_strobe();
        test_blank_write();
        test_write_burst_off();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
